pc_next_ctrl: RTL and testbench
===============================

# pc_next_ctrl

Next-PC controller that drives the data and enable inputs of the processor's 12-bit program-counter register. It observes the current PC and the pipeline's redirect and stall requests, then selects the next fetch address. It tracks multi-cycle stall and post-redirect flush windows with a small state machine and counters. It sits in the fetch stage between decode/execute control and the PC register.

## Interface
- ADDR_WIDTH, 12, width of instruction addresses
- FLUSH_CYCLES, 2, cycles `flush` stays high per redirect (legal range 1..15)
- RESET_VECTOR, 0, `pc_next` value while in reset
- EXC_VECTOR, 12'hFFF, exception handler address

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pc_current  input  ADDR_WIDTH  current PC register output
- stall_req  input  1  hold PC, for example while mult/div is busy
- branch_valid  input  1  taken branch this cycle
- branch_target  input  ADDR_WIDTH  branch destination
- jump_valid  input  1  jump/jal/jr this cycle
- jump_target  input  ADDR_WIDTH  jump destination
- exc_valid  input  1  exception/overflow redirect
- pc_next  output  ADDR_WIDTH  to PC register data input
- pc_en  output  1  to PC register enable
- flush  output  1  squash fetched/decoded instructions
- state  output  2  debug encoding: RUN=0, STALL=1, FLUSH=2
- stall_cnt  output  16  saturating count of cycles with pc_en=0 outside reset

## Operation
- `pc_next`, `pc_en` and `flush` are combinational from the registered state/counter and the current inputs. The PC register therefore captures `pc_next` on the same edge.
- Sequential increment is `pc_current + 1` modulo 2^ADDR_WIDTH; 12'hFFF wraps to 12'h000.
- **RUN**, evaluated in priority order:
  - `exc_valid`: `pc_next`=EXC_VECTOR, `pc_en`=1, `flush`=1. Go to FLUSH with counter=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN.
  - `jump_valid`: same as `exc_valid`, with `jump_target`.
  - `branch_valid`: same as `exc_valid`, with `branch_target`.
  - `stall_req`: `pc_en`=0, `pc_next`=`pc_current`. Go to STALL.
  - Otherwise: `pc_en`=1, `pc_next`=increment.
- **STALL**:
  - `exc_valid`: handled as in RUN.
  - `stall_req`=1 (no exception): `pc_en`=0, stay in STALL.
  - `stall_req`=0: evaluate exactly as RUN with stall_req=0. Jump/branch presented on the release cycle are honored.
- **FLUSH**:
  - `flush`=1, `pc_en`=1, `pc_next`=increment.
  - `branch_valid`, `jump_valid` and `stall_req` are ignored, because they come from squashed instructions.
  - `exc_valid` re-redirects to EXC_VECTOR and reloads counter=FLUSH_CYCLES-1.
  - Counter decrements each cycle. On the cycle it reads 1, the next state is RUN.
- `stall_cnt` increments on every cycle with `pc_en`=0 while reset is high, saturating at 16'hFFFF.

## Timing
- Reset (reset=0, asynchronous):
  - State=RUN, counter=0, `stall_cnt`=0.
  - Outputs forced: `pc_en`=0, `pc_next`=RESET_VECTOR, `flush`=0.
  - Reset asserted mid-STALL or mid-FLUSH aborts immediately.
- First rising edge after reset deasserts: normal RUN evaluation. The PC advances 0→1 if no event is present.
- Redirect latency is 0 cycles: the target is loaded on the same edge the request is sampled.
- Flush window: `flush` is high for exactly FLUSH_CYCLES consecutive cycles, counting the redirect cycle, unless an exception re-extends it.
- Stall release: the PC increments on the first edge where `stall_req`=0.
- Simultaneous events resolve by priority exc > jump > branch > stall.

## Test plan
- Reset, then 5 idle cycles from `pc_current`=0 → `pc_next` sequence 1,2,3,4,5, with `pc_en`=1 and `flush`=0 throughout. During reset, `pc_en`=0 and `pc_next`=0.
- `pc_current`=12'h010 with `branch_valid`=1 and `branch_target`=12'h040 → `pc_next`=12'h040 and `flush`=1 that cycle. Next cycle: `flush`=1, `pc_next`=12'h041. Third cycle: state RUN, `flush`=0.
- `stall_req` held 3 cycles at PC 12'h020 → `pc_en`=0 for 3 cycles and `stall_cnt`=3. On release, `pc_next`=12'h021 with `pc_en`=1.
- `exc_valid`, `jump_valid` and `branch_valid` all high in the same cycle → `pc_next`=12'hFFF and state FLUSH. During FLUSH, `jump_valid`=1 with target 12'h100 → ignored, `pc_next`=12'h000 (wrap).
- `exc_valid` during STALL → immediate redirect to 12'hFFF with `pc_en`=1; the stall is abandoned.
- Reset asserted in the middle of a FLUSH window → outputs go to reset values with no clock edge. After release, state=RUN and `flush`=0.

Source files
------------

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: picks the fetch address and PC enable for the program-counter register.
// It tracks stall and post-redirect flush windows.
module pc_next_ctrl #(
    parameter int unsigned           ADDR_WIDTH   = 12,
    parameter int unsigned           FLUSH_CYCLES = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = '1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_current,
    input  logic                  stall_req,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  exc_valid,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  pc_en,
    output logic                  flush,
    output logic [1:0]            state,
    output logic [15:0]           stall_cnt
);

    localparam int unsigned    CNT_W      = 4;
    localparam int unsigned    STAT_W     = 16;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit             MULTI_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [STAT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   pc_next_int;
    logic                    pc_en_int;
    logic                    flush_int;
    logic                    redirect;
    logic [ADDR_WIDTH-1:0]   redirect_tgt;

    // Next-state and unforced next-PC selection; a redirect opens a flush window.
    always_comb begin
        pc_inc       = ADDR_WIDTH'(pc_current + 1'b1);
        pc_next_int  = pc_inc;
        pc_en_int    = 1'b1;
        flush_int    = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        redirect     = 1'b0;
        redirect_tgt = EXC_VECTOR;

        case (state_q)
            ST_FLUSH: begin
                // Branch, jump and stall requests here come from squashed instructions.
                flush_int = 1'b1;
                if (exc_valid) begin
                    redirect = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(cnt_q - 1'b1);
                    state_d = (cnt_q <= CNT_W'(1)) ? ST_RUN : ST_FLUSH;
                end
            end
            ST_RUN, ST_STALL: begin
                if (exc_valid) begin
                    redirect = 1'b1;
                end else if ((state_q == ST_STALL) && stall_req) begin
                    pc_en_int   = 1'b0;
                    pc_next_int = pc_current;
                end else if (jump_valid) begin
                    redirect     = 1'b1;
                    redirect_tgt = jump_target;
                end else if (branch_valid) begin
                    redirect     = 1'b1;
                    redirect_tgt = branch_target;
                end else if (stall_req) begin
                    pc_en_int   = 1'b0;
                    pc_next_int = pc_current;
                    state_d     = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if (redirect) begin
            pc_next_int = redirect_tgt;
            pc_en_int   = 1'b1;
            flush_int   = 1'b1;
            state_d     = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
            cnt_d       = MULTI_FLUSH ? FLUSH_LOAD : '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en_int && (stall_cnt_q != '1)) begin
            stall_cnt_d = STAT_W'(stall_cnt_q + 1'b1);
        end
    end

    // Outputs are held at their reset values for as long as reset is low, with no clock needed.
    always_comb begin
        pc_next = pc_next_int;
        pc_en   = pc_en_int;
        flush   = flush_int;
        if (!reset) begin
            pc_next = RESET_VECTOR;
            pc_en   = 1'b0;
            flush   = 1'b0;
        end
    end

    // State, flush counter and stall statistic registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Scoreboard bench for pc_next_ctrl: the stimulus side predicts each cycle's outputs, and a monitor compares them.
module tb_pc_next_ctrl;

    localparam int unsigned AW  = 12;
    localparam int          FC  = 2;
    localparam int          EXC = 12'hFFF;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc_current = '0;
    logic          stall_req = 1'b0;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          jump_valid = 1'b0;
    logic [AW-1:0] jump_target = '0;
    logic          exc_valid = 1'b0;
    logic [AW-1:0] pc_next;
    logic          pc_en;
    logic          flush;
    logic [1:0]    state;
    logic [15:0]   stall_cnt;

    pc_next_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .pc_current    (pc_current),
        .stall_req     (stall_req),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .exc_valid     (exc_valid),
        .pc_next       (pc_next),
        .pc_en         (pc_en),
        .flush         (flush),
        .state         (state),
        .stall_cnt     (stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] pc_next;
        logic          pc_en;
        logic          flush;
        logic [1:0]    state;
        logic [15:0]   stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode 0 run, 1 stalled, 2 flushing; rem = flush cycles still owed after this one.
    int m_mode  = 0;
    int m_rem   = 0;
    int m_stall = 0;
    int m_pc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_rem   = 0;
        m_stall = 0;
        m_pc    = 0;
    endtask

    // Drive one cycle's inputs at the falling edge and push the predicted outputs.
    task automatic drive(input bit rst_on, input int pc, input bit e, input bit j, input bit b,
                         input bit s, input int jt, input int bt);
        exp_t ex;
        int   nxt;
        int   nmode;
        int   rem;
        bit   en;
        bit   fl;
        bit   redir;
        int   tgt;
        @(negedge clock);
        reset         = rst_on ? 1'b0 : 1'b1;
        pc_current    = AW'(pc);
        exc_valid     = e;
        jump_valid    = j;
        branch_valid  = b;
        stall_req     = s;
        jump_target   = AW'(jt);
        branch_target = AW'(bt);
        if (rst_on) begin
            model_reset();
            ex = '{pc_next: '0, pc_en: 1'b0, flush: 1'b0, state: 2'd0, stall_cnt: 16'd0};
            exp_q.push_back(ex);
            return;
        end
        nxt   = (pc + 1) % 4096;
        en    = 1'b1;
        fl    = 1'b0;
        nmode = m_mode;
        rem   = m_rem;
        redir = 1'b0;
        tgt   = EXC;
        if (m_mode == 2) begin
            fl = 1'b1;
            if (e) redir = 1'b1;
            else begin
                rem   = m_rem - 1;
                nmode = (rem > 0) ? 2 : 0;
            end
        end else if (e) begin
            redir = 1'b1;
        end else if (m_mode == 1 && s) begin
            en  = 1'b0;
            nxt = pc;
        end else if (j) begin
            redir = 1'b1;
            tgt   = jt;
        end else if (b) begin
            redir = 1'b1;
            tgt   = bt;
        end else if (s) begin
            en    = 1'b0;
            nxt   = pc;
            nmode = 1;
        end else begin
            nmode = 0;
        end
        if (redir) begin
            nxt   = tgt;
            en    = 1'b1;
            fl    = 1'b1;
            rem   = FC - 1;
            nmode = (rem > 0) ? 2 : 0;
        end
        ex = '{pc_next: AW'(nxt), pc_en: en, flush: fl, state: 2'(m_mode), stall_cnt: 16'(m_stall)};
        exp_q.push_back(ex);
        if (!en && m_stall < 65535) m_stall++;
        if (en) m_pc = nxt;
        m_mode = nmode;
        m_rem  = rem;
    endtask

    task automatic idle(input int pc);
        drive(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: compares the DUT against the oldest prediction, mid low phase.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clock);
            #2;
            while (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                chk("pc_next",   32'(pc_next),   32'(ex.pc_next));
                chk("pc_en",     32'(pc_en),     32'(ex.pc_en));
                chk("flush",     32'(flush),     32'(ex.flush));
                chk("state",     32'(state),     32'(ex.state));
                chk("stall_cnt", 32'(stall_cnt), 32'(ex.stall_cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        // Reset with noisy inputs: outputs must stay forced.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, int'($urandom_range(0, 4095)), 1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 12'h456);
        end
        // Five idle cycles from 0: 1,2,3,4,5.
        for (int i = 0; i < 5; i++) idle(m_pc);
        // Taken branch at 0x010 to 0x040, two-cycle flush window.
        drive(1'b0, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h040);
        idle(m_pc);
        idle(m_pc);
        // Three stall cycles at 0x020, then release.
        for (int i = 0; i < 3; i++) drive(1'b0, 12'h020, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        idle(12'h020);
        idle(m_pc);
        // All redirects together: exception wins; jump inside the flush window is ignored.
        drive(1'b0, m_pc, 1'b1, 1'b1, 1'b1, 1'b0, 12'h200, 12'h300);
        drive(1'b0, m_pc, 1'b0, 1'b1, 1'b0, 1'b0, 12'h100, 0);
        idle(m_pc);
        // Exception while stalled.
        drive(1'b0, 12'h050, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        drive(1'b0, 12'h050, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        idle(m_pc);
        idle(m_pc);
        // Jump presented on the stall release cycle is honored.
        drive(1'b0, 12'h070, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        drive(1'b0, 12'h070, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0A0, 0);
        idle(m_pc);
        idle(m_pc);
        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, m_pc,
                  ($urandom % 16) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
                  ($urandom % 3) == 0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        end
        // Asynchronous reset in the middle of a flush window.
        drive(1'b0, 12'h300, 1'b0, 1'b0, 1'b1, 1'b0, 0, 12'h600);
        @(negedge clock);
        #3;
        chk("pre_reset_flush", 32'(flush), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_pc_en",     32'(pc_en),     32'd0);
        chk("async_pc_next",   32'(pc_next),   32'd0);
        chk("async_flush",     32'(flush),     32'd0);
        chk("async_state",     32'(state),     32'd0);
        chk("async_stall_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(m_pc);
        idle(m_pc);
        idle(m_pc);
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clock);
            wait_cyc++;
        end
        @(negedge clock);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
